cmp_hysteresis_monitor: RTL and testbench

CMP_HYSTERESIS_MONITOR -- requirements
Module: cmp_hysteresis_monitor

---
 rtl/cmp_hysteresis_monitor.sv | 159 +++++++++++++++
 tb/tb_cmp_hysteresis_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_hysteresis_monitor.sv
// Hysteresis alarm monitor driven by comparator result flags.
// An alarm is raised after CONFIRM_CNT consecutive "greater" samples and
// dropped after CONFIRM_CNT consecutive "less" samples; cycles without
// in_valid do not break a streak. Per-flag saturating event counters and a
// sticky illegal-sample flag accompany the FSM. All outputs are registered.
module cmp_hysteresis_monitor #(
    parameter int CONFIRM_CNT = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    input  logic             clr_cnt,
    output logic             alarm,
    output logic [1:0]       state,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic             out_valid,
    output logic             err_flag
);

    localparam int STREAK_W = $clog2(CONFIRM_CNT + 1);
    localparam logic [STREAK_W-1:0] CONFIRM_V = STREAK_W'(CONFIRM_CNT);

    typedef enum logic [1:0] {
        ST_LOW     = 2'b00,
        ST_RISING  = 2'b01,
        ST_ALARM   = 2'b10,
        ST_FALLING = 2'b11
    } state_t;

    state_t              state_reg, state_next;
    logic [STREAK_W-1:0] streak_reg, streak_next;
    logic [STREAK_W-1:0] streak_inc;
    logic                rise_reg, rise_next;
    logic                fall_reg, fall_next;
    logic                out_valid_reg;
    logic                err_reg;
    logic [2:0]          flags;
    logic                one_hot;
    logic                accept;
    logic                illegal;
    logic [CNT_W-1:0]    cnt_reg [3];

    // Flag vector order matches the counter array: 0 = gt, 1 = lt, 2 = eq.
    assign flags      = {a_eq_b, a_lt_b, a_gt_b};
    assign one_hot    = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    assign accept     = in_valid && one_hot;
    assign illegal    = in_valid && !one_hot;
    assign streak_inc = streak_reg + STREAK_W'(1);

    // Next-state logic: only accepted samples move the FSM or the streak.
    always_comb begin
        state_next  = state_reg;
        streak_next = streak_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if (accept) begin
            case (state_reg)
                ST_LOW: begin
                    if (a_gt_b) begin
                        state_next  = ST_RISING;
                        streak_next = STREAK_W'(1);
                    end
                end
                ST_RISING: begin
                    if (a_gt_b) begin
                        if (streak_inc == CONFIRM_V) begin
                            state_next  = ST_ALARM;
                            streak_next = '0;
                            rise_next   = 1'b1;
                        end else begin
                            streak_next = streak_inc;
                        end
                    end else begin
                        state_next  = ST_LOW;
                        streak_next = '0;
                    end
                end
                ST_ALARM: begin
                    if (a_lt_b) begin
                        state_next  = ST_FALLING;
                        streak_next = STREAK_W'(1);
                    end
                end
                ST_FALLING: begin
                    if (a_lt_b) begin
                        if (streak_inc == CONFIRM_V) begin
                            state_next  = ST_LOW;
                            streak_next = '0;
                            fall_next   = 1'b1;
                        end else begin
                            streak_next = streak_inc;
                        end
                    end else begin
                        state_next  = ST_ALARM;
                        streak_next = '0;
                    end
                end
                default: begin
                    state_next  = ST_LOW;
                    streak_next = '0;
                end
            endcase
        end
    end

    // FSM, streak, strobes and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_LOW;
            streak_reg    <= '0;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            streak_reg    <= streak_next;
            rise_reg      <= rise_next;
            fall_reg      <= fall_next;
            out_valid_reg <= accept;
            if (illegal) begin
                err_reg <= 1'b1;
            end
        end
    end

    // One saturating counter per flag; clear wins over a same-cycle increment.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst || clr_cnt) begin
                    cnt_reg[gi] <= '0;
                end else if (accept && flags[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // The alarm level is the upper state bit (ALARM and FALLING both hold it).
    assign alarm      = state_reg[1];
    assign state      = state_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
    assign out_valid  = out_valid_reg;
    assign err_flag   = err_reg;
    assign gt_count   = cnt_reg[0];
    assign lt_count   = cnt_reg[1];
    assign eq_count   = cnt_reg[2];

endmodule

// File: tb/tb_cmp_hysteresis_monitor.sv
// Self-checking bench for cmp_hysteresis_monitor (CONFIRM_CNT=4, CNT_W=4).
// A reference model tracks the alarm level, the length of the current
// qualifying run and per-flag event totals; every output is compared after
// each clock edge.
module tb_cmp_hysteresis_monitor;

    localparam int CONF  = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          a_gt_b = 1'b0;
    logic          a_lt_b = 1'b0;
    logic          a_eq_b = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          alarm;
    logic [1:0]    state;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] gt_count;
    logic [CW-1:0] lt_count;
    logic [CW-1:0] eq_count;
    logic          out_valid;
    logic          err_flag;

    cmp_hysteresis_monitor #(
        .CONFIRM_CNT(CONF),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .a_eq_b    (a_eq_b),
        .clr_cnt   (clr_cnt),
        .alarm     (alarm),
        .state     (state),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .gt_count  (gt_count),
        .lt_count  (lt_count),
        .eq_count  (eq_count),
        .out_valid (out_valid),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Reference model: alarm level, current qualifying-run length, totals.
    int m_alarm = 0;
    int m_run   = 0;
    int m_rise  = 0;
    int m_fall  = 0;
    int m_ov    = 0;
    int m_err   = 0;
    int m_cnt [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, v, g, l, e, c);
        int nf;
        if (r) begin
            m_alarm = 0; m_run = 0; m_rise = 0; m_fall = 0; m_ov = 0; m_err = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            nf = int'(g) + int'(l) + int'(e);
            m_rise = 0; m_fall = 0; m_ov = 0;
            if (v && nf != 1) m_err = 1;
            if (c) begin
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end else if (v && nf == 1) begin
                if (g && m_cnt[0] < CMAX) m_cnt[0]++;
                if (l && m_cnt[1] < CMAX) m_cnt[1]++;
                if (e && m_cnt[2] < CMAX) m_cnt[2]++;
            end
            if (v && nf == 1) begin
                m_ov = 1;
                if (m_alarm == 0) begin
                    m_run = g ? m_run + 1 : 0;
                    if (m_run == CONF) begin m_alarm = 1; m_run = 0; m_rise = 1; end
                end else begin
                    m_run = l ? m_run + 1 : 0;
                    if (m_run == CONF) begin m_alarm = 0; m_run = 0; m_fall = 1; end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [1:0] exp_state;
        exp_state = {m_alarm != 0, m_run != 0};
        chk("alarm",      32'(alarm),      32'(m_alarm));
        chk("state",      32'(state),      32'(exp_state));
        chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        chk("out_valid",  32'(out_valid),  32'(m_ov));
        chk("err_flag",   32'(err_flag),   32'(m_err));
        chk("gt_count",   32'(gt_count),   32'(m_cnt[0]));
        chk("lt_count",   32'(lt_count),   32'(m_cnt[1]));
        chk("eq_count",   32'(eq_count),   32'(m_cnt[2]));
    endtask

    // One transaction: drive, clock, update model, sample 1 time unit later.
    task automatic step(input logic r, v, g, l, e, c);
        rst = r; in_valid = v; a_gt_b = g; a_lt_b = l; a_eq_b = e; clr_cnt = c;
        @(posedge clk);
        model_update(r, v, g, l, e, c);
        #1;
        step_no++;
        compare_all();
        $display("step %0d rst=%0b v=%0b gt/lt/eq=%0b%0b%0b clr=%0b -> st=%0d alarm=%0b rp=%0b fp=%0b ov=%0b err=%0b cnt=%0d/%0d/%0d",
                 step_no, r, v, g, l, e, c, state, alarm, rise_pulse, fall_pulse,
                 out_valid, err_flag, gt_count, lt_count, eq_count);
    endtask

    task automatic gt1();  step(0, 1, 1, 0, 0, 0); endtask
    task automatic lt1();  step(0, 1, 0, 1, 0, 0); endtask
    task automatic eq1();  step(0, 1, 0, 0, 1, 0); endtask
    task automatic gap();  step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0); endtask
    task automatic rst1(); step(1, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1)); endtask

    initial begin
        logic r, v, c, g, l, e;
        int mode;
        int pick;

        // Reset held for two cycles with random flags and in_valid high.
        rst1(); rst1();
        chk("reset_state", 32'(state), 32'd0);

        // Four back-to-back gt samples raise the alarm.
        gt1(); gt1(); gt1();
        chk("pre_alarm", 32'(alarm), 32'd0);
        gt1();
        chk("alarm_up", 32'(alarm), 32'd1);
        chk("alarm_state", 32'(state), 32'd2);
        chk("rise_now", 32'(rise_pulse), 32'd1);
        gap();
        chk("rise_gone", 32'(rise_pulse), 32'd0);

        // Broken streak, then a full run with in_valid gaps in between.
        rst1();
        gt1(); gt1(); gt1(); eq1();
        chk("broken_streak", 32'(state), 32'd0);
        gt1(); gap(); gt1(); gap(); gap(); gt1(); gap();
        chk("gap_no_alarm", 32'(alarm), 32'd0);
        gt1();
        chk("gap_alarm", 32'(alarm), 32'd1);
        chk("gt_seven", 32'(gt_count), 32'd7);
        chk("eq_one", 32'(eq_count), 32'd1);

        // Falling path with an interrupted run.
        lt1(); chk("fall_st1", 32'(state), 32'd3);
        lt1(); chk("fall_st2", 32'(state), 32'd3);
        gt1(); chk("fall_back", 32'(state), 32'd2);
        lt1(); chk("fall_st3", 32'(state), 32'd3);
        lt1(); lt1();
        chk("still_alarm", 32'(alarm), 32'd1);
        lt1();
        chk("alarm_down", 32'(alarm), 32'd0);
        chk("fall_now", 32'(fall_pulse), 32'd1);
        chk("lt_six", 32'(lt_count), 32'd6);
        eq1();
        chk("fall_gone", 32'(fall_pulse), 32'd0);

        // Illegal samples: sticky error, nothing else moves.
        step(0, 1, 1, 1, 0, 0);
        chk("err_set", 32'(err_flag), 32'd1);
        chk("err_no_ov", 32'(out_valid), 32'd0);
        step(0, 1, 0, 0, 0, 0);
        gt1(); step(0, 1, 1, 1, 1, 0); step(0, 0, 0, 0, 0, 1);
        chk("err_held", 32'(err_flag), 32'd1);
        rst1();
        chk("err_cleared", 32'(err_flag), 32'd0);

        // Counter saturation, then clear racing a valid gt.
        for (int i = 0; i < 20; i++) eq1();
        chk("eq_sat", 32'(eq_count), 32'd15);
        step(0, 1, 1, 0, 0, 1);
        chk("clr_gt", 32'(gt_count), 32'd0);
        chk("clr_ov", 32'(out_valid), 32'd1);
        chk("clr_state", 32'(state), 32'd1);

        // Reset in the middle of a rising streak of 3.
        gt1(); gt1();
        rst1();
        gt1(); gt1(); gt1();
        chk("fresh_run_low", 32'(alarm), 32'd0);
        gt1();
        chk("fresh_run_up", 32'(alarm), 32'd1);

        // Randomized traffic with runs biased toward gt or lt.
        mode = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 1);
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) begin
                g = $urandom_range(0, 1); l = $urandom_range(0, 1); e = $urandom_range(0, 1);
            end else begin
                pick = $urandom_range(0, 9);
                if (pick < 8) begin
                    g = (mode == 0); l = (mode == 1); e = 1'b0;
                end else begin
                    g = 1'b0; l = (mode == 0); e = (mode == 1);
                    if (pick == 9) begin l = 1'b0; e = 1'b1; end
                end
            end
            step(r, v, g, l, e, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout step=%0d", step_no);
        $fatal(1, "timeout");
    end

endmodule
